// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and default width for the multiply/divide unit
package mdu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - conditional two's-complement negate of a W-bit value
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MIPS-style HI/LO multiply/divide unit
// One radix-2 shift-add or restoring-divide step per cycle on magnitudes, signs fixed up at the end.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            divz,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t state, state_nxt;

  logic [CNTW-1:0] count;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] qr;
  logic [XLEN-1:0] opnd;
  logic            is_div;
  logic            neg_q;
  logic            neg_r;

  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod_res;
  logic [XLEN-1:0]   quo_res, rem_res;
  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     div_diff;
  logic              zero_div;

  mdu_sign_fix #(.W(XLEN)) u_a_mag (.x(a), .neg(~op[0] & a[XLEN-1]), .y(a_mag));
  mdu_sign_fix #(.W(XLEN)) u_b_mag (.x(b), .neg(~op[0] & b[XLEN-1]), .y(b_mag));

  mdu_sign_fix #(.W(2*XLEN)) u_prod (.x({acc, qr}), .neg(neg_q), .y(prod_res));
  mdu_sign_fix #(.W(XLEN))   u_quo  (.x(qr),        .neg(neg_q), .y(quo_res));
  mdu_sign_fix #(.W(XLEN))   u_rem  (.x(acc),       .neg(neg_r), .y(rem_res));

  assign zero_div = op[1] && (b == '0);

  // acc/qr form one double-width shift register: {hi partial, multiplier} or {remainder, quotient}
  always_comb begin
    addend   = qr[0] ? opnd : '0;
    mul_sum  = {1'b0, acc} + {1'b0, addend};
    rem_sh   = {acc, qr[XLEN-1]};
    div_diff = rem_sh - {1'b0, opnd};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !flush && !zero_div) state_nxt = op[1] ? DIV : MUL;
      MUL, DIV: begin
        if (flush)                    state_nxt = IDLE;
        else if (count == CNTW'(1))   state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      divz   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      acc    <= '0;
      qr     <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && start) begin
            if (zero_div) begin
              lo   <= '1;
              hi   <= a;
              divz <= 1'b1;
              done <= 1'b1;
            end else begin
              busy   <= 1'b1;
              divz   <= 1'b0;
              acc    <= '0;
              opnd   <= op[1] ? b_mag : a_mag;
              qr     <= op[1] ? a_mag : b_mag;
              count  <= CNTW'(XLEN);
              is_div <= op[1];
              neg_q  <= ~op[0] & (a[XLEN-1] ^ b[XLEN-1]);
              neg_r  <= ~op[0] & a[XLEN-1];
            end
          end else if (!flush) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        MUL: begin
          if (flush) busy <= 1'b0;
          else begin
            acc   <= mul_sum[XLEN:1];
            qr    <= {mul_sum[0], qr[XLEN-1:1]};
            count <= count - CNTW'(1);
          end
        end
        DIV: begin
          if (flush) busy <= 1'b0;
          else begin
            if (!div_diff[XLEN]) begin
              acc <= div_diff[XLEN-1:0];
              qr  <= {qr[XLEN-2:0], 1'b1};
            end else begin
              acc <= rem_sh[XLEN-1:0];
              qr  <= {qr[XLEN-2:0], 1'b0};
            end
            count <= count - CNTW'(1);
          end
        end
        FIX: begin
          busy <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              lo <= quo_res;
              hi <= rem_res;
            end else begin
              {hi, lo} <= prod_res;
            end
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench: vector table, random ops vs arithmetic model, abort/back-to-back sequences
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, divz;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .divz(divz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic ed);
    logic signed [63:0] sp;
    logic [63:0]        up;
    ed = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        {eh, el} = sp;
      end
      2'b01: begin
        up = {32'b0, x} * {32'b0, y};
        {eh, el} = up;
      end
      default: begin
        if (y == 32'd0) begin
          eh = x; el = 32'hFFFFFFFF; ed = 1'b1;
        end else if (o == 2'b11) begin
          el = x / y; eh = x % y;
        end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          el = x; eh = 32'd0;
        end else begin
          el = $signed(x) / $signed(y);
          eh = $signed(x) % $signed(y);
        end
      end
    endcase
  endfunction

  // issue one op and wait (bounded) for completion, checking latency and busy length
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed, input string tag);
    int n;
    int nb;
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    if (ed) begin
      chk({tag, " dz_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, " dz_done"}, {63'd0, done}, 64'd1);
      chk({tag, " dz_flag"}, {63'd0, divz}, 64'd1);
      chk({tag, " dz_hi"}, {32'd0, hi}, {32'd0, eh});
      chk({tag, " dz_lo"}, {32'd0, lo}, {32'd0, el});
    end else begin
      nb = busy ? 1 : 0;
      n = 0;
      got = 1'b0;
      for (int i = 1; i <= 100 && !got; i++) begin
        @(posedge clk); #1;
        if (done) begin got = 1'b1; n = i; end
        else if (busy) nb++;
      end
      chk({tag, " latency"}, 64'(n), 64'd33);
      chk({tag, " busy_cycles"}, 64'(nb), 64'd33);
      chk({tag, " result"}, {hi, lo}, {eh, el});
      chk({tag, " divz"}, {63'd0, divz}, 64'd0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] eh, el, sv_lo;
    logic        ed;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          saw_done;

    vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
    vecs.push_back('{2'b11, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{2'b11, 32'h00000064, 32'h7,        32'h00000002, 32'h0000000E, 1'b0});
    vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0});
    vecs.push_back('{2'b10, 32'h80000000, 32'h0,        32'h80000000, 32'hFFFFFFFF, 1'b1});

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {29'd0, busy, done, divz, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
            $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      model(ro, ra, rb, eh, el, ed);
      do_op(ro, ra, rb, eh, el, ed, $sformatf("rnd%0d", i));
    end

    // mthi/mtlo in IDLE, both in one cycle and singly
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h11112222;
    @(posedge clk); #1;
    chk("wr_both", {hi, lo}, 64'h11112222_11112222);
    @(negedge clk);
    wr_lo = 1'b0; wdata = 32'hAAAA0000;
    @(posedge clk); #1;
    chk("wr_hi_only", {hi, lo}, 64'hAAAA0000_11112222);

    // start beats a simultaneous write; flush at cycle 10 leaves HI/LO alone
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h0000BEEF;
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; wr_lo = 1'b0;
    chk("start_prio_lo", {32'd0, lo}, 64'h11112222);
    chk("start_busy", {63'd0, busy}, 64'd1);
    saw_done = 1'b0;
    repeat (9) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    repeat (40) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    chk("flush_no_done", {63'd0, saw_done}, 64'd0);
    chk("flush_hilo", {hi, lo}, 64'hAAAA0000_11112222);
    chk("flush_divz", {63'd0, divz}, 64'd0);

    // flush coinciding with start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b11; a = 32'd9; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", {62'd0, busy, done}, 64'd0);
    chk("idle_flush_hilo", {hi, lo}, 64'hAAAA0000_11112222);

    // flush on the FIX edge suppresses completion
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fix_flush_done", {62'd0, busy, done}, 64'd0);
    chk("fix_flush_hilo", {hi, lo}, 64'hAAAA0000_11112222);

    // back-to-back: stray start and write while busy ignored, new start in the done cycle
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    sv_lo = lo;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      start = (i == 5); wr_lo = (i == 5); op = 2'b11; a = 32'd9; b = 32'd0; wdata = 32'h0000DEAD;
      @(posedge clk); #1;
      if (i == 5) begin
        chk("busy_ignore_lo", {32'd0, lo}, {32'd0, sv_lo});
        chk("busy_ignore_state", {62'd0, busy, divz}, 64'd2);
      end
    end
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    @(posedge clk); #1;
    chk("b2b_first_done", {63'd0, done}, 64'd1);
    chk("b2b_first_result", {hi, lo}, 64'd15);
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept", {63'd0, busy}, 64'd1);
    saw_done = 1'b0;
    repeat (32) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    chk("b2b_no_early_done", {63'd0, saw_done}, 64'd0);
    @(posedge clk); #1;
    chk("b2b_second_done", {63'd0, done}, 64'd1);
    chk("b2b_second_result", {hi, lo}, {32'd2, 32'd14});

    // asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'hFFFFFFF9; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_ctl", {61'd0, busy, done, divz}, 64'd0);
    chk("rst_async_hilo", {hi, lo}, 64'd0);
    saw_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    chk("rst_no_done", {63'd0, saw_done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
